// File: rtl/lcd_char_render.sv
// Character renderer: walks one glyph from a font ROM row by row and streams
// one coloured pixel per accepted pix_valid/pix_ready handshake.
module lcd_char_render #(
  parameter logic [15:0] FG_COLOR   = 16'hFFFF,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  parameter logic [11:0] SMALL_BASE = 12'd1536
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        en_size,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_color,
  output logic        show_char_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  ascii_q, ascii_d;
  logic [8:0]  sx_q, sx_d, sy_q, sy_d;
  logic        size_q, size_d;
  logic [3:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic        pix_valid_q, pix_valid_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_color_q, pix_color_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [2:0]  last_col_s;
  logic [3:0]  last_row_s;
  logic [11:0] ascii_ext_s;

  assign last_col_s  = size_q ? 3'd7 : 3'd5;
  assign last_row_s  = size_q ? 4'd15 : 4'd11;
  assign ascii_ext_s = {5'd0, ascii_q};

  // Next-state logic; pixel outputs are registered from the next state so
  // they line up with the SHIFT state and stay frozen while stalled.
  always_comb begin
    state_d     = state_q;
    ascii_d     = ascii_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    size_d      = size_q;
    row_d       = row_q;
    col_d       = col_q;
    shreg_d     = shreg_q;
    rom_addr_d  = rom_addr_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    case (state_q)
      IDLE: begin
        if (show_char_flag) begin
          ascii_d = (ascii_num > 7'd94) ? 7'd0 : ascii_num;
          sx_d    = start_x;
          sy_d    = start_y;
          size_d  = en_size;
          row_d   = 4'd0;
          col_d   = 3'd0;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (size_q) begin
          rom_addr_d = {1'b0, ascii_q, row_q};
        end else begin
          rom_addr_d = SMALL_BASE + (ascii_ext_s << 3) + (ascii_ext_s << 2) + {8'd0, row_q};
        end
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d = rom_data;
        col_d   = 3'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (pix_ready) begin
          if (col_q == last_col_s) begin
            if (row_q == last_row_s) begin
              state_d = DONE;
            end else begin
              row_d   = row_q + 4'd1;
              state_d = FETCH;
            end
          end else begin
            col_d   = col_q + 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
          end
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pix_valid_d = (state_d == SHIFT);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    if (state_d == SHIFT) begin
      pix_x_d     = sx_d + {6'd0, col_d};
      pix_y_d     = sy_d + {5'd0, row_d};
      pix_color_d = shreg_d[7] ? FG_COLOR : BG_COLOR;
    end else begin
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      pix_color_d = pix_color_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      ascii_q     <= 7'd0;
      sx_q        <= 9'd0;
      sy_q        <= 9'd0;
      size_q      <= 1'b0;
      row_q       <= 4'd0;
      col_q       <= 3'd0;
      shreg_q     <= 8'd0;
      rom_addr_q  <= 12'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 9'd0;
      pix_y_q     <= 9'd0;
      pix_color_q <= 16'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ascii_q     <= ascii_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      size_q      <= size_d;
      row_q       <= row_d;
      col_q       <= col_d;
      shreg_q     <= shreg_d;
      rom_addr_q  <= rom_addr_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign pix_valid      = pix_valid_q;
  assign pix_x          = pix_x_q;
  assign pix_y          = pix_y_q;
  assign pix_color      = pix_color_q;
  assign show_char_done = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_lcd_char_render.sv
// Bench for lcd_char_render: random font ROM, glyph-level pixel reference model,
// directed scenarios for timing, wrap, backpressure, ignored flags and reset abort.
module tb_lcd_char_render;

  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;
  localparam int SB = 1536;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        show_char_flag;
  logic [6:0]  ascii_num;
  logic [8:0]  start_x, start_y;
  logic        en_size;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pix_valid, pix_ready;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_color;
  logic        show_char_done, busy;

  logic [7:0]  rom_mem [0:4095];
  int total = 0;
  int passed = 0;

  typedef struct {int x; int y; int c;} pix_t;

  always #5 sys_clk = ~sys_clk;

  // Font ROM: data for the registered address is available in the next cycle.
  assign rom_data = rom_mem[rom_addr];

  lcd_char_render dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .show_char_flag(show_char_flag),
    .ascii_num(ascii_num), .start_x(start_x), .start_y(start_y), .en_size(en_size),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .show_char_done(show_char_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int glyph_base(input int a, input bit sz);
    int g;
    g = (a > 94) ? 0 : a;
    return sz ? g * 16 : SB + g * 12;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
    check({tag, "_done"}, {31'd0, show_char_done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_addr"}, {20'd0, rom_addr}, 32'd0);
    check({tag, "_x"}, {23'd0, pix_x}, 32'd0);
    check({tag, "_y"}, {23'd0, pix_y}, 32'd0);
    check({tag, "_color"}, {16'd0, pix_color}, 32'd0);
  endtask

  task automatic run_glyph(input int a, input int sx, input int sy, input bit sz,
                           input bit rnd, input int mid);
    pix_t exp_q[$];
    pix_t p;
    int k, first_k, done_k, dones, base, rows, cols, n_acc, npix;
    logic prev_v, prev_r;
    logic [8:0] px, py;
    logic [15:0] pc;
    logic [7:0] b;
    base = glyph_base(a, sz);
    rows = sz ? 16 : 12;
    cols = sz ? 8 : 6;
    for (int r = 0; r < rows; r++) begin
      b = rom_mem[base + r];
      for (int c = 0; c < cols; c++) begin
        p.x = (sx + c) % 512;
        p.y = (sy + r) % 512;
        p.c = b[7 - c] ? int'(FG) : int'(BG);
        exp_q.push_back(p);
      end
    end
    npix = exp_q.size();
    ascii_num = 7'(a);
    start_x = 9'(sx);
    start_y = 9'(sy);
    en_size = sz;
    pix_ready = 1'b1;
    show_char_flag = 1'b1;
    @(posedge sys_clk); #1;
    show_char_flag = 1'b0;
    k = 0; first_k = -1; done_k = -1; dones = 0; n_acc = 0;
    prev_v = 1'b0; prev_r = 1'b1; px = '0; py = '0; pc = '0;
    check("busy_on", {31'd0, busy}, 32'd1);
    while (k < 3000 && !(done_k >= 0 && k > done_k + 3)) begin
      if (k == 1) check("rom_addr_row0", {20'd0, rom_addr}, 32'(base));
      if (prev_v && !prev_r) begin
        check("stall_valid", {31'd0, pix_valid}, 32'd1);
        check("stall_x", {23'd0, pix_x}, {23'd0, px});
        check("stall_y", {23'd0, pix_y}, {23'd0, py});
        check("stall_color", {16'd0, pix_color}, {16'd0, pc});
      end
      if (pix_valid && first_k < 0) first_k = k;
      if (show_char_done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k == done_k + 1) check("busy_off", {31'd0, busy}, 32'd0);
      if (k == 20 && mid >= 0) begin
        ascii_num = 7'(mid);
        show_char_flag = 1'b1;
      end else begin
        show_char_flag = 1'b0;
      end
      pix_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pix_valid && pix_ready) begin
        n_acc++;
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          check("pix_x", {23'd0, pix_x}, 32'(p.x));
          check("pix_y", {23'd0, pix_y}, 32'(p.y));
          check("pix_color", {16'd0, pix_color}, 32'(p.c));
        end
      end
      prev_v = pix_valid; prev_r = pix_ready;
      px = pix_x; py = pix_y; pc = pix_color;
      @(posedge sys_clk); #1;
      k++;
    end
    pix_ready = 1'b1;
    show_char_flag = 1'b0;
    check("pixels_left", 32'(exp_q.size()), 32'd0);
    check("accepted", 32'(n_acc), 32'(npix));
    check("done_count", 32'(dones), 32'd1);
    if (!rnd) begin
      // k counts edges after the sampling edge N; +1 gives the edge where the value is sampled
      check("first_valid_edge", 32'(first_k + 1), 32'd3);
      check("done_edge", 32'(done_k + 1), sz ? 32'd161 : 32'd97);
    end
  endtask

  initial begin
    int n, k, dones;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'd0;
    for (int i = 0; i < 12; i++) rom_mem[SB + i] = 8'd0;
    sys_rst = 1'b1; show_char_flag = 1'b0; ascii_num = 7'd0;
    start_x = 9'd0; start_y = 9'd0; en_size = 1'b0; pix_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    run_glyph(40, 128, 16, 1'b1, 1'b0, -1);
    run_glyph(1, 0, 0, 1'b0, 1'b0, -1);
    run_glyph(55, 200, 300, 1'b1, 1'b1, -1);
    run_glyph(33, 508, 100, 1'b1, 1'b0, -1);
    run_glyph(20, 300, 505, 1'b0, 1'b0, -1);
    run_glyph(10, 50, 60, 1'b1, 1'b0, 77);
    run_glyph(100, 70, 80, 1'b1, 1'b0, -1);

    // Abort a glyph at pixel 40 with a reset and make sure no done appears.
    ascii_num = 7'd33; start_x = 9'd10; start_y = 9'd20; en_size = 1'b1;
    pix_ready = 1'b1; show_char_flag = 1'b1;
    @(posedge sys_clk); #1;
    show_char_flag = 1'b0;
    n = 0; k = 0;
    while (n < 40 && k < 500) begin
      if (pix_valid) n++;
      @(posedge sys_clk); #1;
      k++;
    end
    check("reached_pixel_40", 32'(n), 32'd40);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    check_reset_outputs("abort");
    sys_rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      if (show_char_done) dones++;
      @(posedge sys_clk); #1;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_glyph(62, 1, 2, 1'b0, 1'b1, -1);

    for (int t = 0; t < 3; t++) begin
      run_glyph(int'($urandom_range(0, 127)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 511)), 1'($urandom), 1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
